// File: rtl/aes_decrypt_sequencer_if.sv
// rtl/aes_decrypt_sequencer_if.sv - block/plaintext handshakes and datapath bus of the AES decipher sequencer
// With AES_SEQ_KEYGATE_EN defined the bundle also carries key_valid.
interface aes_decrypt_sequencer_if #(
  parameter int NR = 10
);
  localparam int KW = $clog2(NR + 1);

  logic          in_valid;
  logic          in_ready;
  logic [127:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  out_data;
  logic [127:0]  dp_state;
  logic [1:0]    dp_mode;
  logic [KW-1:0] key_idx;
  logic [127:0]  dp_result;
  logic          busy;
`ifdef AES_SEQ_KEYGATE_EN
  logic          key_valid;
`endif

  modport master (
`ifdef AES_SEQ_KEYGATE_EN
    input  key_valid,
`endif
    input  in_valid, in_data, out_ready, dp_result,
    output in_ready, out_valid, out_data, dp_state, dp_mode, key_idx, busy
  );

  modport slave (
`ifdef AES_SEQ_KEYGATE_EN
    output key_valid,
`endif
    output in_valid, in_data, out_ready, dp_result,
    input  in_ready, out_valid, out_data, dp_state, dp_mode, key_idx, busy
  );
endinterface

// File: rtl/aes_decrypt_sequencer.sv
// rtl/aes_decrypt_sequencer.sv - FSM stepping an external inverse-round datapath through one AES decryption
// Optional AES_SEQ_KEYGATE_EN: in IDLE a block is only accepted while key_valid is high.
module aes_decrypt_sequencer #(
  parameter int NR = 10
) (
  input logic                     clk,
  input logic                     rst,
  aes_decrypt_sequencer_if.master bus
);
  localparam int KW = $clog2(NR + 1);

  localparam logic [1:0] MODE_ARK  = 2'b00;
  localparam logic [1:0] MODE_FULL = 2'b01;
  localparam logic [1:0] MODE_LAST = 2'b10;
  localparam logic [1:0] MODE_IDLE = 2'b11;

  localparam logic [KW-1:0] KEY_TOP   = KW'(NR);
  localparam logic [KW-1:0] RND_FIRST = KW'(NR - 1);
  localparam logic [KW-1:0] RND_ONE   = KW'(1);

  if (NR != 10 && NR != 12 && NR != 14) begin : g_nr_check
    $error("aes_decrypt_sequencer: NR must be 10, 12 or 14");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_t;

  state_t        fsm_q;
  logic [127:0]  state_q;
  logic [KW-1:0] rnd_q;
  logic [KW-1:0] kidx_q;
  logic [1:0]    mode_q;
  logic          busy_q;
  logic          out_valid_q;
  logic          key_ok;

`ifdef AES_SEQ_KEYGATE_EN
  assign key_ok = bus.key_valid;
`else
  assign key_ok = 1'b1;
`endif

  // Gated by rst so the handshake reads not-ready for the whole reset pulse.
  assign bus.in_ready  = (fsm_q == S_IDLE) && !rst && key_ok;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = state_q;
  assign bus.dp_state  = state_q;
  assign bus.dp_mode   = mode_q;
  assign bus.key_idx   = kidx_q;
  assign bus.busy      = busy_q;

  // Control outputs are registered alongside the state, so they carry the
  // values belonging to the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= S_IDLE;
      state_q     <= '0;
      rnd_q       <= '0;
      kidx_q      <= '0;
      mode_q      <= MODE_IDLE;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (fsm_q)
        S_IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            state_q <= bus.in_data;
            fsm_q   <= S_INIT;
            mode_q  <= MODE_ARK;
            kidx_q  <= KEY_TOP;
            busy_q  <= 1'b1;
          end
        end
        S_INIT: begin
          state_q <= bus.dp_result;
          rnd_q   <= RND_FIRST;
          fsm_q   <= S_ROUND;
          mode_q  <= MODE_FULL;
          kidx_q  <= RND_FIRST;
        end
        S_ROUND: begin
          state_q <= bus.dp_result;
          if (rnd_q == RND_ONE) begin
            fsm_q  <= S_FINAL;
            mode_q <= MODE_LAST;
            kidx_q <= '0;
          end else begin
            rnd_q  <= rnd_q - RND_ONE;
            kidx_q <= rnd_q - RND_ONE;
          end
        end
        S_FINAL: begin
          state_q     <= bus.dp_result;
          fsm_q       <= S_DONE;
          mode_q      <= MODE_IDLE;
          kidx_q      <= '0;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b1;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            fsm_q       <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          fsm_q       <= S_IDLE;
          mode_q      <= MODE_IDLE;
          kidx_q      <= '0;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aes_decrypt_sequencer.sv
// tb/tb_aes_decrypt_sequencer.sv - bench for aes_decrypt_sequencer with an AES-128 inverse-round datapath model
// Covers the AES_SEQ_KEYGATE_EN build when that macro is defined.
module tb_aes_decrypt_sequencer;
  localparam int NR = 10;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

  typedef struct {
    logic [127:0] ct;
    int           hold;
    logic [127:0] pt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [31:0]  w     [44];
  logic [127:0] rk    [16];

  aes_decrypt_sequencer_if #(.NR(NR)) bus ();
  aes_decrypt_sequencer #(.NR(NR)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // One datapath step; byte i of the block is state row i%4, column i/4.
  function automatic logic [127:0] inv_step(input logic [127:0] s, input logic [1:0] mode, input logic [127:0] k);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [127:0] r;
    if (mode == 2'b11) return s;
    for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
    if (mode != 2'b00) begin
      for (int i = 0; i < 16; i++) b[i] = isbox[a[4*(((i/4) - (i%4) + 4) % 4) + (i%4)]];
      a = b;
    end
    for (int i = 0; i < 16; i++) a[i] = a[i] ^ k[127-8*i -: 8];
    if (mode == 2'b01) begin
      for (int c = 0; c < 4; c++) begin
        b[4*c+0] = gm(a[4*c], 8'h0e) ^ gm(a[4*c+1], 8'h0b) ^ gm(a[4*c+2], 8'h0d) ^ gm(a[4*c+3], 8'h09);
        b[4*c+1] = gm(a[4*c], 8'h09) ^ gm(a[4*c+1], 8'h0e) ^ gm(a[4*c+2], 8'h0b) ^ gm(a[4*c+3], 8'h0d);
        b[4*c+2] = gm(a[4*c], 8'h0d) ^ gm(a[4*c+1], 8'h09) ^ gm(a[4*c+2], 8'h0e) ^ gm(a[4*c+3], 8'h0b);
        b[4*c+3] = gm(a[4*c], 8'h0b) ^ gm(a[4*c+1], 8'h0d) ^ gm(a[4*c+2], 8'h09) ^ gm(a[4*c+3], 8'h0e);
      end
      a = b;
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = a[i];
    return r;
  endfunction

  // Whole inverse cipher as a plain loop over the round keys.
  function automatic logic [127:0] aes_decrypt(input logic [127:0] ct);
    logic [127:0] s;
    s = inv_step(ct, 2'b00, rk[NR]);
    for (int r = NR - 1; r >= 1; r--) s = inv_step(s, 2'b01, rk[r]);
    return inv_step(s, 2'b10, rk[0]);
  endfunction

  assign bus.dp_result = inv_step(bus.dp_state, bus.dp_mode, rk[bus.key_idx]);

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic build_tables();
    logic [7:0]   inv;
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [127:0] key;
    for (int i = 0; i < 256; i++) begin
      inv = 8'h00;
      for (int j = 1; j < 256; j++) if (gm(i[7:0], j[7:0]) == 8'h01) inv = j[7:0];
      sbox[i] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    for (int i = 0; i < 256; i++) isbox[sbox[i]] = i[7:0];
    key = C1_KEY;
    rc = 8'h01;
    for (int i = 0; i < 44; i++) begin
      if (i < 4) w[i] = key[127-32*i -: 32];
      else begin
        t = w[i-1];
        if (i % 4 == 0) begin
          t = {t[23:0], t[31:24]};
          t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
          rc = xt(rc);
        end
        w[i] = w[i-4] ^ t;
      end
    end
    for (int r = 0; r < 16; r++) rk[r] = (r <= NR) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  // Entered at a negedge with the sequencer idle; leaves it idle again.
  task automatic run_block(input logic [127:0] ct, input int hold, output logic [127:0] pt, output int lat);
    int k;
    int busy_cnt;
    int wt;
    logic [127:0] held;
    bus.in_data = ct;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    wt = 0;
    while (!bus.in_ready && wt < 40) begin
      @(negedge clk);
      wt++;
    end
    chki("accept_ready", int'(bus.in_ready), 1);
    k = 0;
    busy_cnt = 0;
    do begin
      @(negedge clk);
      k++;
      if (k <= NR + 1) begin
        chki("key_idx", int'(bus.key_idx), NR + 1 - k);
        chki("dp_mode", int'(bus.dp_mode), (k == 1) ? 0 : ((k == NR + 1) ? 2 : 1));
      end
      if (bus.busy) busy_cnt++;
      bus.in_valid = 1'($urandom);
      bus.in_data = {$urandom, $urandom, $urandom, $urandom};
    end while (!bus.out_valid && k < 40);
    lat = k - 1;
    chki("latency", lat, NR + 1);
    chki("busy_cycles", busy_cnt, NR + 1);
    chki("done_in_ready", int'(bus.in_ready), 0);
    held = bus.out_data;
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.in_data = ~ct;
      @(negedge clk);
      chki("hold_valid", int'(bus.out_valid), 1);
      chk("hold_data", bus.out_data, held);
      chki("hold_in_ready", int'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chki("valid_drop", int'(bus.out_valid), 0);
    chki("ready_resume", int'(bus.in_ready), 1);
    bus.out_ready = 1'b0;
    pt = held;
  endtask

  vec_t         tbl [4];
  logic [127:0] pt;
  logic [127:0] ct;
  int           lat;
  int           n;
  int           acc;
  int           outs;
  int           acc_at [2];
  int           ov_cnt;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
`ifdef AES_SEQ_KEYGATE_EN
    bus.key_valid = 1'b1;
`endif
    build_tables();
    chk("model_c1", aes_decrypt(C1_CT), C1_PT);

    repeat (3) @(negedge clk);
    chki("rst_in_ready", int'(bus.in_ready), 0);
    chki("rst_out_valid", int'(bus.out_valid), 0);
    chki("rst_busy", int'(bus.busy), 0);
    chki("rst_dp_mode", int'(bus.dp_mode), 3);
    chki("rst_key_idx", int'(bus.key_idx), 0);
    chk("rst_dp_state", bus.dp_state, 128'h0);
    rst = 1'b0;
    @(negedge clk);
    chki("idle_in_ready", int'(bus.in_ready), 1);
    chki("idle_busy", int'(bus.busy), 0);

    tbl[0] = '{C1_CT, 0, C1_PT};
    tbl[1] = '{C1_CT, 5, C1_PT};
    tbl[2] = '{128'h0, 2, aes_decrypt(128'h0)};
    tbl[3] = '{{4{32'hdeadbeef}}, 1, aes_decrypt({4{32'hdeadbeef}})};
    for (int v = 0; v < 4; v++) begin
      run_block(tbl[v].ct, tbl[v].hold, pt, lat);
      chk("table_pt", pt, tbl[v].pt);
    end

    // Back-to-back with in_valid and out_ready both held high.
    n = 0; acc = 0; outs = 0;
    bus.in_data = C1_CT;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    while (n < 60 && outs < 2) begin
      if (bus.in_valid && bus.in_ready && acc < 2) begin
        acc_at[acc] = n;
        acc++;
      end
      if (bus.out_valid) begin
        chk("b2b_pt", bus.out_data, C1_PT);
        outs++;
      end
      @(negedge clk);
      n++;
      if (acc == 2) bus.in_valid = 1'b0;
    end
    chki("b2b_outputs", outs, 2);
    chki("b2b_spacing", (acc == 2) ? acc_at[1] - acc_at[0] : -1, NR + 3);
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Reset while the round key index reads 5.
    bus.in_data = C1_CT;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b0;
    while (!(bus.busy && bus.key_idx == 4'd5) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chki("mid_key_idx", int'(bus.key_idx), 5);
    rst = 1'b1;
    #1;
    chki("mid_rst_in_ready", int'(bus.in_ready), 0);
    chki("mid_rst_busy", int'(bus.busy), 0);
    chki("mid_rst_dp_mode", int'(bus.dp_mode), 3);
    chki("mid_rst_key_idx", int'(bus.key_idx), 0);
    chk("mid_rst_out_data", bus.out_data, 128'h0);
    chk("mid_rst_dp_state", bus.dp_state, 128'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ov_cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.out_valid) ov_cnt++;
    end
    chki("mid_rst_no_valid", ov_cnt, 0);
    run_block(C1_CT, 0, pt, lat);
    chk("post_rst_pt", pt, C1_PT);

`ifdef AES_SEQ_KEYGATE_EN
    bus.key_valid = 1'b0;
    bus.in_data = C1_CT;
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chki("kg_ready_low", int'(bus.in_ready), 0);
      chki("kg_no_accept", int'(bus.busy), 0);
    end
    bus.key_valid = 1'b1;
    #1;
    chki("kg_ready_high", int'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chki("kg_accepted", int'(bus.busy), 1);
    n = 1;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 5) bus.key_valid = 1'b0;
    end
    chki("kg_latency", n - 1, NR + 1);
    chk("kg_pt", bus.out_data, C1_PT);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.key_valid = 1'b1;
`endif

    for (int r = 0; r < 12; r++) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ct = {$urandom, $urandom, $urandom, $urandom};
      run_block(ct, $urandom_range(0, 3), pt, lat);
      chk("rand_pt", pt, aes_decrypt(ct));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_decrypt_sequencer.md
# aes_decrypt_sequencer

Iterative control unit for the AES decipher datapath. It accepts one 128-bit ciphertext block over a valid/ready handshake and holds the working state in its own register. It steps an external single-round inverse datapath through the initial AddRoundKey, NR-1 full inverse rounds and the final inverse round, selecting the round key for each step. The plaintext is returned over a second valid/ready handshake. It sits between the key-schedule/round-key bus and the combinational inverse-round logic, replacing free-running count-based sequencing with an explicit FSM.

## Interface
- NR, 10, number of AES rounds; legal values 10, 12, 14; any other value is an elaboration error.
- KW, derived: $clog2(NR+1), width of key_idx.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  ciphertext offered.
- in_ready  out  1  sequencer can accept a block.
- in_data  in  128  ciphertext block.
- out_valid  out  1  plaintext available.
- out_ready  in  1  consumer accepts plaintext.
- out_data  out  128  plaintext; meaningful only while out_valid=1.
- dp_state  out  128  current working state driven to the datapath.
- dp_mode  out  2  datapath step select:
  - 00: AddRoundKey only.
  - 01: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
  - 10: InvShiftRows, InvSubBytes, AddRoundKey.
  - 11: idle.
- key_idx  out  KW  round key select; the datapath uses RoundKeys[key_idx*128 +: 128].
- dp_result  in  128  combinational datapath result for the current dp_state/dp_mode/key_idx.
- busy  out  1  high in INIT, ROUND and FINAL.

## Operation
- FSM states: IDLE, INIT, ROUND, FINAL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: state_q<=in_data, go to INIT.
- INIT:
  - dp_mode=00, key_idx=NR.
  - At the edge: state_q<=dp_result, rnd_q<=NR-1, go to ROUND.
- ROUND:
  - dp_mode=01, key_idx=rnd_q.
  - At the edge: state_q<=dp_result.
  - If rnd_q==1, go to FINAL; otherwise rnd_q<=rnd_q-1.
- FINAL:
  - dp_mode=10, key_idx=0.
  - At the edge: state_q<=dp_result, go to DONE.
- DONE:
  - out_valid=1.
  - On out_ready: go to IDLE.
- Outputs in each state:
  - dp_state=state_q in all states.
  - out_data=state_q.
  - In IDLE and DONE: dp_mode=11, key_idx=0.
- Arithmetic: rnd_q is KW bits, decrement only, never below 1; there is no wrap path.
- in_ready=1 only in IDLE. in_valid is ignored in every other state, and in_data is sampled only on an accepted handshake.
- out_data is stable while out_valid=1 and out_ready=0.
- Reset, at any time including mid-block:
  - FSM goes to IDLE, state_q=0, rnd_q=0.
  - The partial result is discarded; no out_valid pulse is produced for the aborted block.
- Reset values of outputs while rst=1: in_ready=0, out_valid=0, busy=0, dp_mode=11, key_idx=0, dp_state=0, out_data=0.

## Timing
- Accept edge T.
  - INIT occupies cycle T+1.
  - ROUND occupies T+2..T+NR.
  - FINAL occupies T+NR+1.
  - out_valid rises after edge T+NR+1, which is NR+1 cycles after acceptance (11 for NR=10).
- Minimum block period is NR+3 cycles: accept, NR+1 compute cycles, DONE, IDLE. With out_ready held high the next accept is possible 2 cycles after out_valid rises.
- No combinational path from in_valid or out_ready to any output.
- dp_result is sampled once per compute cycle and must settle within one clk period.

## Configuration
- AES_SEQ_KEYGATE_EN defined:
  - Adds input key_valid (1 bit).
  - In IDLE, in_ready=key_valid.
  - key_valid falling during INIT, ROUND or FINAL does not stop the block.
- Not defined:
  - Port key_valid is absent.
  - in_ready=1 whenever the FSM is in IDLE and rst=0.

## Test plan
- FIPS-197 C.1 (NR=10, key 000102…0f):
  - Stimulus: in_data=69c4e0d86a7b0430d8cdb78070b4c55a, out_ready=1.
  - Required: out_valid exactly 11 cycles after accept; out_data=00112233445566778899aabbccddeeff; out_valid for one cycle.
- Key sequence:
  - key_idx must read 10,9,8,7,6,5,4,3,2,1,0 on consecutive cycles.
  - dp_mode must read 00, then 01 nine times, then 10.
  - busy must be high for exactly 11 cycles.
- Output backpressure:
  - Stimulus: out_ready=0 for 5 cycles after out_valid rises.
  - Required: out_valid and out_data hold constant; in_ready=0; a second in_valid is ignored. Acceptance resumes 1 cycle after out_ready rises.
- Back-to-back blocks:
  - Stimulus: two C.1 ciphertexts with in_valid held high and out_ready=1.
  - Required: both outputs equal 00112233…eeff; accept edges are 13 cycles apart.
- Reset mid-block:
  - Stimulus: assert rst while key_idx=5.
  - Required: all outputs reach reset values immediately; no out_valid is produced. A fresh block after release completes correctly.
- With AES_SEQ_KEYGATE_EN:
  - key_valid=0 with in_valid=1: in_ready=0 and no accept.
  - key_valid raised: accept on the next edge.
  - key_valid dropped mid-ROUND: the block still completes in 11 cycles.
